wb_arbiter: RTL and testbench

Two-master, one-slave Wishbone (B4 classic) arbiter that shares the single data-memory bus between the instruction fetch stage (ifm) and the execute/memory stage (exm). It is a registered grant state machine with round-robin tie-breaking, a combinational request/response mux, and a bus watchdog that terminates stalled cycles with an error. It sits between the two stage masters and the external memory interconnect.

---
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Two-master Wishbone B4 classic arbiter (ifm/exm) with round-robin
//            tie-break, combinational bus mux and stalled-cycle watchdog.
// Revision : 1.0
// ============================================================================
module wb_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] ifm_wb_adr_i,
   input  logic [31:0] ifm_wb_dat_i,
   output logic [31:0] ifm_wb_dat_o,
   input  logic        ifm_wb_we_i,
   input  logic [3:0]  ifm_wb_sel_i,
   input  logic        ifm_wb_stb_i,
   input  logic        ifm_wb_cyc_i,
   output logic        ifm_wb_ack_o,
   output logic        ifm_wb_err_o,
   input  logic [31:0] exm_wb_adr_i,
   input  logic [31:0] exm_wb_dat_i,
   output logic [31:0] exm_wb_dat_o,
   input  logic        exm_wb_we_i,
   input  logic [3:0]  exm_wb_sel_i,
   input  logic        exm_wb_stb_i,
   input  logic        exm_wb_cyc_i,
   output logic        exm_wb_ack_o,
   output logic        exm_wb_err_o,
   output logic [31:0] s_wb_adr_o,
   output logic [31:0] s_wb_dat_o,
   output logic        s_wb_we_o,
   output logic [3:0]  s_wb_sel_o,
   output logic        s_wb_stb_o,
   output logic        s_wb_cyc_o,
   input  logic [31:0] s_wb_dat_i,
   input  logic        s_wb_ack_i
);

   localparam int                 c_CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [c_CNT_W-1:0] c_LIMIT    = c_CNT_W'(TIMEOUT);
   localparam logic [1:0]         c_ST_IDLE  = 2'd0;
   localparam logic [1:0]         c_ST_IFM   = 2'd1;
   localparam logic [1:0]         c_ST_EXM   = 2'd2;
   localparam logic               c_LAST_IFM = 1'b0;
   localparam logic               c_LAST_EXM = 1'b1;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic               r_last;
   logic               w_last_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic               w_own_ifm;
   logic               w_own_exm;
   logic               w_own_stb;
   logic               w_timeout;

   assign w_own_ifm = (r_state == c_ST_IFM);
   assign w_own_exm = (r_state == c_ST_EXM);
   assign w_own_stb = (w_own_ifm & ifm_wb_stb_i) | (w_own_exm & exm_wb_stb_i);
   // An ack landing on the limit cycle completes the transfer, so it suppresses err.
   assign w_timeout = (TIMEOUT != 0) && w_own_stb && !s_wb_ack_i && (r_cnt == c_LIMIT);

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      case (r_state)
         c_ST_IDLE: begin
            if (ifm_wb_cyc_i && exm_wb_cyc_i)
               w_state_nxt = (r_last == c_LAST_IFM) ? c_ST_EXM : c_ST_IFM;
            else if (ifm_wb_cyc_i)
               w_state_nxt = c_ST_IFM;
            else if (exm_wb_cyc_i)
               w_state_nxt = c_ST_EXM;
         end
         c_ST_IFM: begin
            if (!ifm_wb_cyc_i) begin
               w_last_nxt  = c_LAST_IFM;
               w_state_nxt = exm_wb_cyc_i ? c_ST_EXM : c_ST_IDLE;
            end
         end
         c_ST_EXM: begin
            if (!exm_wb_cyc_i) begin
               w_last_nxt  = c_LAST_EXM;
               w_state_nxt = ifm_wb_cyc_i ? c_ST_IFM : c_ST_IDLE;
            end
         end
         default: w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= c_ST_IDLE;
         r_last  <= c_LAST_IFM;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         if ((TIMEOUT == 0) || (w_state_nxt != r_state) || s_wb_ack_i || !w_own_stb || w_timeout)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + c_CNT_W'(1);
      end
   end

   always_comb begin
      s_wb_adr_o   = '0;
      s_wb_dat_o   = '0;
      s_wb_we_o    = 1'b0;
      s_wb_sel_o   = '0;
      s_wb_stb_o   = 1'b0;
      s_wb_cyc_o   = 1'b0;
      ifm_wb_ack_o = 1'b0;
      exm_wb_ack_o = 1'b0;
      ifm_wb_err_o = 1'b0;
      exm_wb_err_o = 1'b0;
      if (w_own_ifm) begin
         s_wb_adr_o   = ifm_wb_adr_i;
         s_wb_dat_o   = ifm_wb_dat_i;
         s_wb_we_o    = ifm_wb_we_i;
         s_wb_sel_o   = ifm_wb_sel_i;
         s_wb_stb_o   = ifm_wb_stb_i;
         s_wb_cyc_o   = ifm_wb_cyc_i;
         ifm_wb_ack_o = s_wb_ack_i;
         ifm_wb_err_o = w_timeout;
      end else if (w_own_exm) begin
         s_wb_adr_o   = exm_wb_adr_i;
         s_wb_dat_o   = exm_wb_dat_i;
         s_wb_we_o    = exm_wb_we_i;
         s_wb_sel_o   = exm_wb_sel_i;
         s_wb_stb_o   = exm_wb_stb_i;
         s_wb_cyc_o   = exm_wb_cyc_i;
         exm_wb_ack_o = s_wb_ack_i;
         exm_wb_err_o = w_timeout;
      end
   end

   assign ifm_wb_dat_o = s_wb_dat_i;
   assign exm_wb_dat_o = s_wb_dat_i;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Directed scenarios plus randomized traffic against a reference model.
// Revision : 1.0
// ============================================================================
module tb_wb_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] ifm_adr, ifm_wdat, exm_adr, exm_wdat, s_dat;
   logic        ifm_we, exm_we, ifm_stb, exm_stb, ifm_cyc, exm_cyc, s_ack;
   logic [3:0]  ifm_sel, exm_sel;
   logic [31:0] ifm_rdat, exm_rdat, s_adr_o, s_dat_o;
   logic        ifm_ack, exm_ack, ifm_err, exm_err, s_we_o, s_stb_o, s_cyc_o;
   logic [3:0]  s_sel_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .ifm_wb_adr_i(ifm_adr), .ifm_wb_dat_i(ifm_wdat), .ifm_wb_dat_o(ifm_rdat),
      .ifm_wb_we_i(ifm_we), .ifm_wb_sel_i(ifm_sel), .ifm_wb_stb_i(ifm_stb),
      .ifm_wb_cyc_i(ifm_cyc), .ifm_wb_ack_o(ifm_ack), .ifm_wb_err_o(ifm_err),
      .exm_wb_adr_i(exm_adr), .exm_wb_dat_i(exm_wdat), .exm_wb_dat_o(exm_rdat),
      .exm_wb_we_i(exm_we), .exm_wb_sel_i(exm_sel), .exm_wb_stb_i(exm_stb),
      .exm_wb_cyc_i(exm_cyc), .exm_wb_ack_o(exm_ack), .exm_wb_err_o(exm_err),
      .s_wb_adr_o(s_adr_o), .s_wb_dat_o(s_dat_o), .s_wb_we_o(s_we_o),
      .s_wb_sel_o(s_sel_o), .s_wb_stb_o(s_stb_o), .s_wb_cyc_o(s_cyc_o),
      .s_wb_dat_i(s_dat), .s_wb_ack_i(s_ack)
   );

   function automatic logic [70:0] bus_of(input logic [31:0] a, input logic [31:0] d,
                                          input logic we, input logic [3:0] sel,
                                          input logic stb, input logic cyc);
      return {a, d, we, sel, stb, cyc};
   endfunction

   function automatic logic [70:0] sbus();
      return {s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o};
   endfunction

   task automatic idle_inputs();
      ifm_adr = $urandom; ifm_wdat = $urandom; ifm_we = 1'b0; ifm_sel = 4'h0;
      exm_adr = $urandom; exm_wdat = $urandom; exm_we = 1'b0; exm_sel = 4'h0;
      ifm_stb = 1'b0; ifm_cyc = 1'b0; exm_stb = 1'b0; exm_cyc = 1'b0;
      s_ack = 1'b0; s_dat = $urandom;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      idle_inputs();
      ifm_cyc = 1'b1; ifm_stb = 1'b1; exm_cyc = 1'b1; exm_stb = 1'b1;
      s_ack = 1'b1; s_dat = 32'hA5A5_0001;
      @(negedge clk);
      total++;
      if (sbus() !== 71'd0) begin bad++; $display("FAIL reset_bus got=%h want=0", sbus()); end
      total++;
      if ({ifm_ack, exm_ack, ifm_err, exm_err} !== 4'b0000) begin
         bad++; $display("FAIL reset_ack_err got=%b want=0000", {ifm_ack, exm_ack, ifm_err, exm_err});
      end
      total++;
      if ({ifm_rdat, exm_rdat} !== {s_dat, s_dat}) begin
         bad++; $display("FAIL reset_rdat got=%h/%h want=%h", ifm_rdat, exm_rdat, s_dat);
      end
      tick();
      idle_inputs();
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      total++;
      if (sbus() !== 71'd0) begin bad++; $display("FAIL reset_idle_bus got=%h want=0", sbus()); end
      tick();
   endtask

   task automatic test_single_write();
      int n_exm_ack = 0;
      int n_ifm_ack = 0;
      exm_adr = 32'h0000_1000; exm_wdat = 32'hDEAD_BEEF; exm_sel = 4'hF; exm_we = 1'b1;
      exm_cyc = 1'b1; exm_stb = 1'b1;
      for (int c = 0; c < 6; c++) begin
         s_ack = (c == 3);
         if (c == 4) begin exm_cyc = 1'b0; exm_stb = 1'b0; end
         @(negedge clk);
         n_exm_ack += int'(exm_ack);
         n_ifm_ack += int'(ifm_ack);
         if (c >= 1 && c <= 3) begin
            total++;
            if (sbus() !== bus_of(32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 4'hF, 1'b1, 1'b1)) begin
               bad++; $display("FAIL write_bus c=%0d got=%h", c, sbus());
            end
         end else if (c != 4) begin
            total++;
            if (sbus() !== 71'd0) begin bad++; $display("FAIL write_idle c=%0d got=%h want=0", c, sbus()); end
         end
         tick();
      end
      total++;
      if (n_exm_ack !== 1) begin bad++; $display("FAIL write_exm_ack pulses=%0d want=1", n_exm_ack); end
      total++;
      if (n_ifm_ack !== 0) begin bad++; $display("FAIL write_ifm_ack pulses=%0d want=0", n_ifm_ack); end
      idle_inputs();
   endtask

   task automatic test_tie();
      do_reset();
      ifm_adr = 32'h0000_0100; exm_adr = 32'h0000_0200;
      ifm_cyc = 1'b1; ifm_stb = 1'b1; exm_cyc = 1'b1; exm_stb = 1'b1;
      tick();
      @(negedge clk);
      total++;
      if ({s_adr_o, s_cyc_o} !== {32'h0000_0200, 1'b1}) begin
         bad++; $display("FAIL tie_first got adr=%h cyc=%b want adr=00000200 cyc=1", s_adr_o, s_cyc_o);
      end
      tick();
      exm_cyc = 1'b0; exm_stb = 1'b0;
      tick();
      @(negedge clk);
      total++;
      if ({s_adr_o, s_cyc_o} !== {32'h0000_0100, 1'b1}) begin
         bad++; $display("FAIL tie_handover got adr=%h cyc=%b want adr=00000100 cyc=1", s_adr_o, s_cyc_o);
      end
      tick();
      ifm_cyc = 1'b0; ifm_stb = 1'b0;
      tick();
      ifm_cyc = 1'b1; ifm_stb = 1'b1; exm_cyc = 1'b1; exm_stb = 1'b1;
      @(negedge clk);
      total++;
      if (sbus() !== 71'd0) begin bad++; $display("FAIL tie_gap got=%h want=0", sbus()); end
      tick();
      @(negedge clk);
      total++;
      if (s_adr_o !== 32'h0000_0200) begin
         bad++; $display("FAIL tie_second got adr=%h want=00000200", s_adr_o);
      end
      idle_inputs();
      tick();
      tick();
   endtask

   task automatic test_block();
      ifm_adr = 32'h0000_3000; ifm_wdat = 32'h1111_2222; ifm_sel = 4'h3; ifm_we = 1'b0;
      ifm_cyc = 1'b1; ifm_stb = 1'b1;
      tick();
      exm_adr = 32'h0000_4000; exm_wdat = 32'h3333_4444; exm_sel = 4'hC; exm_we = 1'b1;
      exm_cyc = 1'b1; exm_stb = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         s_ack = c[0];
         ifm_stb = (c != 4);
         @(negedge clk);
         total++;
         if (sbus() !== bus_of(ifm_adr, ifm_wdat, ifm_we, ifm_sel, ifm_stb, 1'b1)) begin
            bad++; $display("FAIL block_bus c=%0d got=%h", c, sbus());
         end
         total++;
         if ({ifm_ack, exm_ack} !== {s_ack, 1'b0}) begin
            bad++; $display("FAIL block_ack c=%0d got=%b want=%b", c, {ifm_ack, exm_ack}, {s_ack, 1'b0});
         end
         tick();
      end
      s_ack = 1'b0; ifm_cyc = 1'b0; ifm_stb = 1'b0;
      tick();
      exm_cyc = 1'b0; exm_stb = 1'b0;
      tick();
      idle_inputs();
   endtask

   task automatic test_timeout();
      ifm_adr = 32'h0000_5000; ifm_stb = 1'b1; ifm_cyc = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c == 8) begin ifm_cyc = 1'b0; ifm_stb = 1'b0; end
         @(negedge clk);
         if (c >= 1 && c <= 8) begin
            total++;
            if ({ifm_err, exm_err} !== {(c == 5), 1'b0}) begin
               bad++; $display("FAIL timeout_err c=%0d got=%b want=%b", c, {ifm_err, exm_err}, {(c == 5), 1'b0});
            end
         end
         if (c == 6 || c == 7) begin
            total++;
            if ({s_adr_o, s_cyc_o} !== {32'h0000_5000, 1'b1}) begin
               bad++; $display("FAIL timeout_hold c=%0d got adr=%h cyc=%b", c, s_adr_o, s_cyc_o);
            end
         end
         if (c == 9) begin
            total++;
            if (sbus() !== 71'd0) begin bad++; $display("FAIL timeout_release got=%h want=0", sbus()); end
         end
         tick();
      end
      ifm_stb = 1'b1; ifm_cyc = 1'b1;
      for (int c = 0; c < 8; c++) begin
         s_ack = (c == 5);
         if (c == 6) begin ifm_cyc = 1'b0; ifm_stb = 1'b0; end
         @(negedge clk);
         if (c >= 1) begin
            total++;
            if ({ifm_err, exm_err, ifm_ack} !== {2'b00, (c == 5)}) begin
               bad++; $display("FAIL ack_at_limit c=%0d got err/ack=%b want=%b", c, {ifm_err, exm_err, ifm_ack}, {2'b00, (c == 5)});
            end
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      exm_adr = 32'h0000_6000; exm_cyc = 1'b1; exm_stb = 1'b1;
      tick();
      tick();
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0; exm_cyc = 1'b0; exm_stb = 1'b0;
      tick();
      exm_cyc = 1'b1; exm_stb = 1'b1; ifm_adr = 32'h0000_7000;
      tick();
      @(negedge clk);
      total++;
      if ({s_adr_o, s_cyc_o} !== {32'h0000_6000, 1'b1}) begin
         bad++; $display("FAIL rstmid_pre got adr=%h cyc=%b", s_adr_o, s_cyc_o);
      end
      s_ack = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({sbus(), ifm_ack, exm_ack, ifm_err, exm_err} !== 75'd0) begin
         bad++; $display("FAIL rstmid_async got bus=%h acks/errs=%b", sbus(), {ifm_ack, exm_ack, ifm_err, exm_err});
      end
      s_ack = 1'b0; ifm_cyc = 1'b1; ifm_stb = 1'b1;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (sbus() !== 71'd0) begin bad++; $display("FAIL rstmid_idle got=%h want=0", sbus()); end
      tick();
      @(negedge clk);
      total++;
      if (s_adr_o !== 32'h0000_6000) begin
         bad++; $display("FAIL rstmid_tie got adr=%h want=00006000", s_adr_o);
      end
      idle_inputs();
      tick();
      tick();
   endtask

   task automatic test_random();
      int          m_owner = 0;
      int          m_last  = 1;
      int          m_run   = 0;
      int          nxt;
      logic        own_stb, e;
      logic [70:0] exp_bus;
      logic [138:0] exp_v, obs_v;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         ifm_cyc = ifm_cyc ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 3) == 0);
         exm_cyc = exm_cyc ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 3) == 0);
         ifm_stb = $urandom_range(0, 4) != 0;
         exm_stb = $urandom_range(0, 4) != 0;
         ifm_adr = $urandom; ifm_wdat = $urandom; ifm_we = 1'($urandom); ifm_sel = 4'($urandom);
         exm_adr = $urandom; exm_wdat = $urandom; exm_we = 1'($urandom); exm_sel = 4'($urandom);
         s_ack   = $urandom_range(0, 4) == 0;
         s_dat   = $urandom;
         @(negedge clk);
         own_stb = (m_owner == 1) ? ifm_stb : (m_owner == 2) ? exm_stb : 1'b0;
         e = (m_owner != 0) && own_stb && !s_ack && (((m_run + 1) % (TO + 1)) == 0);
         if (m_owner == 1)      exp_bus = bus_of(ifm_adr, ifm_wdat, ifm_we, ifm_sel, ifm_stb, ifm_cyc);
         else if (m_owner == 2) exp_bus = bus_of(exm_adr, exm_wdat, exm_we, exm_sel, exm_stb, exm_cyc);
         else                   exp_bus = 71'd0;
         exp_v = {exp_bus, (m_owner == 1) && s_ack, (m_owner == 2) && s_ack,
                  e && (m_owner == 1), e && (m_owner == 2), s_dat, s_dat};
         obs_v = {sbus(), ifm_ack, exm_ack, ifm_err, exm_err, ifm_rdat, exm_rdat};
         total++;
         if (obs_v !== exp_v) begin
            bad++; $display("FAIL random n=%0d got=%h want=%h", n, obs_v, exp_v);
         end
         @(posedge clk);
         nxt = m_owner;
         if (m_owner == 0) begin
            if (ifm_cyc && exm_cyc) nxt = 3 - m_last;
            else if (ifm_cyc)       nxt = 1;
            else if (exm_cyc)       nxt = 2;
         end else if (!((m_owner == 1) ? ifm_cyc : exm_cyc)) begin
            m_last = m_owner;
            nxt = ((m_owner == 1) ? exm_cyc : ifm_cyc) ? 3 - m_owner : 0;
         end
         if (nxt != m_owner || !own_stb || s_ack) m_run = 0;
         else                                     m_run++;
         m_owner = nxt;
         #1;
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_write();
      test_tie();
      test_block();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
